// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : sequential ALU. Single-cycle base group plus an optional
// multi-cycle multiply/divide group (radix-2 shift-add multiplier and
// restoring divider sharing one working register).
//
// Build option:
//   ALU_SEQ_MEXT_EN  defined   -> multiply/divide group implemented.
//                    undefined -> no M hardware; a mext=1 request completes
//                                 in one cycle with y=0, zero=1, less=0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid            in_ready  accepting (IDLE only)
//   a, b       operands (XLEN)          ctr       4-bit op code
//   mext       1 = multiply/divide group, 0 = base group
//   out_valid  result valid (DONE only) out_ready consumer accepts result
//   y          registered result        zero/less registered flags
//   state_dbg  current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// operands and ctr are captured on that edge. A result transfers on a rising
// edge where out_valid && out_ready; y/zero/less hold while out_ready=0. The
// block returns to IDLE after the result transfer, so a new request can never
// be accepted in the same cycle a result is delivered.
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctr,
  input  logic            mext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            zero,
  output logic            less,
  output logic [1:0]      state_dbg
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Base group (combinational from the live inputs, registered on acceptance)
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   diff_ext;
  logic [XLEN-1:0] diff;
  logic            ovf;
  logic            base_less;
  logic            use_sub;
  logic [XLEN-1:0] addsub;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_y;

  always_comb begin
    diff_ext  = {1'b0, a} - {1'b0, b};
    diff      = diff_ext[XLEN-1:0];
    // Signed overflow of a-b: operands differ in sign and result sign != a.
    ovf       = (a[XLEN-1] ^ b[XLEN-1]) & (a[XLEN-1] ^ diff[XLEN-1]);
    base_less = (ctr[2:0] == 3'b010) ? (diff[XLEN-1] ^ ovf) : diff_ext[XLEN];
    // slt/sltu always subtract so zero reflects a==b for them.
    use_sub   = ctr[3] | (ctr[2:1] == 2'b01);
    addsub    = use_sub ? diff : (a + b);
    shamt     = b[SHW-1:0];
    base_y    = '0;
    case (ctr[2:0])
      3'b000: base_y = addsub;
      3'b001: base_y = a << shamt;
      3'b010,
      3'b011: base_y = {{(XLEN-1){1'b0}}, base_less};
      3'b100: base_y = a ^ b;
      3'b101: base_y = ctr[3] ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
      3'b110: base_y = a | b;
      default: base_y = a & b;
    endcase
  end

`ifdef ALU_SEQ_MEXT_EN
  // ---------------------------------------------------------------------------
  // Multiply/divide group. Both units work on magnitudes; signs are applied
  // to the final iteration's value as it is written into y.
  // w holds {hi, lo}: product {acc, multiplier} or divide {remainder, quotient}.
  // ---------------------------------------------------------------------------
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [SHW-1:0]    cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   d;
  logic [2*XLEN-1:0] w;

  logic              signed_a;
  logic              signed_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_y;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] w_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   m_y;

  always_comb begin
    signed_a  = (ctr[2:0] == 3'b001) || (ctr[2:0] == 3'b010) ||
                (ctr[2:0] == 3'b100) || (ctr[2:0] == 3'b110);
    signed_b  = (ctr[2:0] == 3'b001) || (ctr[2:0] == 3'b100) ||
                (ctr[2:0] == 3'b110);
    a_neg     = signed_a & a[XLEN-1];
    b_neg     = signed_b & b[XLEN-1];
    abs_a     = a_neg ? (-a) : a;
    abs_b     = b_neg ? (-b) : b;
    div_zero  = ctr[2] && (b == '0);
    div_ovf   = ctr[2] && !ctr[0] && (a == MIN_NEG) && (b == '1);
    // ctr[1] selects rem/remu among the divide ops.
    if (div_zero) special_y = ctr[1] ? a : '1;
    else          special_y = ctr[1] ? '0 : a;

    mul_sum   = {1'b0, w[2*XLEN-1:XLEN]} + (w[0] ? {1'b0, d} : '0);
    div_shift = {w[2*XLEN-1:XLEN], w[XLEN-1]};
    div_trial = div_shift - {1'b0, d};
    if (op_q[2]) begin
      // Borrow out of the trial subtraction means restore the old remainder.
      if (div_trial[XLEN]) w_next = {div_shift[XLEN-1:0], w[XLEN-2:0], 1'b0};
      else                 w_next = {div_trial[XLEN-1:0], w[XLEN-2:0], 1'b1};
    end else begin
      w_next = {mul_sum, w[XLEN-1:1]};
    end

    prod_fix = neg_q ? (-w_next) : w_next;
    q_fix    = neg_q ? (-w_next[XLEN-1:0]) : w_next[XLEN-1:0];
    r_fix    = neg_r ? (-w_next[2*XLEN-1:XLEN]) : w_next[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:  m_y = prod_fix[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  m_y = prod_fix[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  m_y = q_fix;
      default: m_y = r_fix;
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      zero  <= 1'b0;
      less  <= 1'b0;
`ifdef ALU_SEQ_MEXT_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mext) begin
              y     <= base_y;
              zero  <= (addsub == '0);
              less  <= base_less;
              state <= DONE;
            end else begin
`ifdef ALU_SEQ_MEXT_EN
              if (div_zero || div_ovf) begin
                y     <= special_y;
                zero  <= (special_y == '0);
                less  <= 1'b0;
                state <= DONE;
              end else begin
                cnt   <= '0;
                op_q  <= ctr[2:0];
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                d     <= ctr[2] ? abs_b : abs_a;
                w     <= {{XLEN{1'b0}}, (ctr[2] ? abs_a : abs_b)};
                state <= CALC;
              end
`else
              y     <= '0;
              zero  <= 1'b1;
              less  <= 1'b0;
              state <= DONE;
`endif
            end
          end
        end
        CALC: begin
`ifdef ALU_SEQ_MEXT_EN
          w   <= w_next;
          cnt <= cnt + SHW'(1);
          // The last iteration writes its signed-corrected value directly.
          if (cnt == CNT_LAST) begin
            y     <= m_y;
            zero  <= (m_y == '0);
            less  <= 1'b0;
            state <= DONE;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal values: 8, 16, 32, 64).
REQ-002 SHALL have derived localparam SHW = $clog2(XLEN), the shift-amount width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  XLEN  operand A.
REQ-008 b  input  XLEN  operand B.
REQ-009 ctr  input  4  operation code, decoded per REQ-014/REQ-015.
REQ-010 mext  input  1  1 = multiply/divide group, 0 = base group.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 y  output  XLEN; zero  output  1; less  output  1  registered result and flags.

Function
REQ-014 Base group (mext=0), ctr[2:0]: 000 add (ctr[3]=0) or sub (ctr[3]=1); 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl (ctr[3]=0) or sra (ctr[3]=1); 110 or; 111 and. Shift amount is b[SHW-1:0]; slt/sltu return {XLEN-1 zeros, less}.
REQ-015 M group (mext=1), ctr[2:0]: 000 mul (low XLEN bits); 001 mulh (signed x signed); 010 mulhsu (signed a x unsigned b); 011 mulhu; 100 div; 101 divu; 110 rem; 111 remu. ctr[3] is ignored.
REQ-016 less SHALL be signed a<b for ctr[2:0]=010 and unsigned a<b otherwise, computed from a-b (carry, and overflow XOR sign bit), over the full XLEN width.
REQ-017 For base ops, zero SHALL equal (add/sub result == 0); slt/sltu force subtraction internally. For M ops, zero = (y == 0) and less = 0.
REQ-018 FSM states: IDLE, CALC, DONE. in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 IDLE with in_valid: a base op goes to DONE (latency 1 cycle); a mul/div op goes to CALC.
REQ-020 CALC: radix-2 shift-add multiplier or restoring divider; exactly XLEN iterations, then DONE; M-op latency = XLEN+1 cycles.
REQ-021 Divide by zero SHALL go directly to DONE with quotient all ones (div/divu) and remainder a (rem/remu).
REQ-022 Signed overflow (a = most negative, b = -1) SHALL go directly to DONE with quotient a and remainder 0.
REQ-023 DONE: y, zero and less are held stable while out_ready=0; with out_ready=1, go to IDLE on the next edge. A new request cannot be accepted in the same cycle.
REQ-024 Operands and ctr SHALL be captured at acceptance; later input changes do not affect the result.

Reset
REQ-025 With rst_n=0 at a clock edge: state = IDLE, y = 0, zero = 0, less = 0, out_valid = 0, iteration counter = 0.
REQ-026 Reset during CALC or DONE SHALL abort the operation with no result delivered; in_ready = 1 on the first cycle after release.

Configuration
REQ-027 Macro ALU_SEQ_MEXT_EN defined: M group is implemented per REQ-015 to REQ-022.
REQ-028 Macro ALU_SEQ_MEXT_EN undefined: no multiply/divide hardware; a mext=1 request completes in 1 cycle with y = 0, zero = 1, less = 0; CALC is unreachable.

Verification
REQ-029 XLEN=32, add 0x7FFFFFFF+1 -> y=0x80000000, zero=0, out_valid on the cycle after acceptance.
REQ-030 slt a=0xFFFFFFFF, b=1 -> y=1, less=1; sltu with the same operands -> y=0, less=0.
REQ-031 sra a=0x80000000, b=0x24 -> y=0xF8000000 (shift amount 4); srl with the same operands -> y=0x08000000.
REQ-032 With ALU_SEQ_MEXT_EN: mulh a=0xFFFFFFFF, b=0xFFFFFFFF -> y=0, out_valid exactly 33 cycles after acceptance; mulhu -> y=0xFFFFFFFE.
REQ-033 div a=7, b=0 -> y=0xFFFFFFFF in 1 cycle; rem a=0x80000000, b=0xFFFFFFFF -> y=0; divu 100/7 -> y=14.
REQ-034 Hold out_ready=0 for 5 cycles: y remains stable and in_ready=0; pulse rst_n=0 during CALC -> out_valid never asserts for that request, and in_ready=1 on the first cycle after release.
